logic_unit_arbiter: RTL and testbench



---
 rtl/logic_unit_arbiter.sv | 159 +++++++++++++++
 tb/tb_logic_unit_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one registered AND/OR/XOR/pass unit among NREQ requesters.
// Optional macro LOGIC_UNIT_ARBITER_PARITY_EN adds rsp_par (XOR-reduction of rsp_y).
//
// state | meaning
// IDLE  | waiting for any req; winner latched and granted on the edge
// EXEC  | computing result from latched operands
// RESP  | holding response until rsp_valid & rsp_ready
module logic_unit_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int ID_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [2*NREQ-1:0]     op,
    input  logic [WIDTH*NREQ-1:0] a_in,
    input  logic [WIDTH*NREQ-1:0] b_in,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [WIDTH-1:0]      rsp_y
`ifdef LOGIC_UNIT_ARBITER_PARITY_EN
    ,
    output logic                  rsp_par
`endif
);

    generate
        if (ID_W != $clog2(NREQ)) begin : g_bad_id_w
            $error("logic_unit_arbiter: ID_W must equal clog2(NREQ)");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t           state, state_nxt;
    logic [ID_W-1:0]  ptr, ptr_nxt;
    logic [ID_W-1:0]  id, id_nxt;
    logic [1:0]       op_q, op_nxt;
    logic [WIDTH-1:0] a_q, a_nxt;
    logic [WIDTH-1:0] b_q, b_nxt;
    logic [NREQ-1:0]  gnt_nxt;
    logic             rsp_valid_nxt;
    logic [ID_W-1:0]  rsp_id_nxt;
    logic [WIDTH-1:0] rsp_y_nxt;
    logic [WIDTH-1:0] y_calc;
    logic             found;
    logic [ID_W-1:0]  win;
`ifdef LOGIC_UNIT_ARBITER_PARITY_EN
    logic             rsp_par_nxt;
`endif

    // Scan starts at ptr and wraps, so the most recently served requester is checked last.
    always_comb begin : p_scan
        int idx;
        idx   = 0;
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = ID_W'(idx);
            end
        end
    end

    always_comb begin
        case (op_q)
            2'b00:   y_calc = a_q & b_q;
            2'b01:   y_calc = a_q | b_q;
            2'b10:   y_calc = a_q ^ b_q;
            default: y_calc = a_q;
        endcase
    end

    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        id_nxt        = id;
        op_nxt        = op_q;
        a_nxt         = a_q;
        b_nxt         = b_q;
        gnt_nxt       = '0;
        rsp_valid_nxt = rsp_valid;
        rsp_id_nxt    = rsp_id;
        rsp_y_nxt     = rsp_y;
`ifdef LOGIC_UNIT_ARBITER_PARITY_EN
        rsp_par_nxt   = rsp_par;
`endif
        case (state)
            S_IDLE: begin
                if (found) begin
                    op_nxt       = op[2*win +: 2];
                    a_nxt        = a_in[WIDTH*win +: WIDTH];
                    b_nxt        = b_in[WIDTH*win +: WIDTH];
                    id_nxt       = win;
                    gnt_nxt[win] = 1'b1;
                    state_nxt    = S_EXEC;
                end
            end
            S_EXEC: begin
                rsp_y_nxt     = y_calc;
                rsp_id_nxt    = id;
                rsp_valid_nxt = 1'b1;
`ifdef LOGIC_UNIT_ARBITER_PARITY_EN
                rsp_par_nxt   = ^y_calc;
`endif
                state_nxt     = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    ptr_nxt       = (id == ID_W'(NREQ - 1)) ? '0 : id + 1'b1;
                    state_nxt     = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ptr       <= '0;
            id        <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            gnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_y     <= '0;
`ifdef LOGIC_UNIT_ARBITER_PARITY_EN
            rsp_par   <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            id        <= id_nxt;
            op_q      <= op_nxt;
            a_q       <= a_nxt;
            b_q       <= b_nxt;
            gnt       <= gnt_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_id    <= rsp_id_nxt;
            rsp_y     <= rsp_y_nxt;
`ifdef LOGIC_UNIT_ARBITER_PARITY_EN
            rsp_par   <= rsp_par_nxt;
`endif
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Scoreboard bench for logic_unit_arbiter: expected responses queued at stimulus time,
// popped when a response handshake is observed.
module tb_logic_unit_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int ID_W  = 2;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req = '0;
    logic [2*NREQ-1:0]     op = '0;
    logic [WIDTH*NREQ-1:0] a_in = '0;
    logic [WIDTH*NREQ-1:0] b_in = '0;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b1;
    logic [ID_W-1:0]       rsp_id;
    logic [WIDTH-1:0]      rsp_y;
`ifdef LOGIC_UNIT_ARBITER_PARITY_EN
    logic                  rsp_par;
`endif

    logic_unit_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .op        (op),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .busy      (busy),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_y     (rsp_y)
`ifdef LOGIC_UNIT_ARBITER_PARITY_EN
        ,
        .rsp_par   (rsp_par)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ID_W-1:0]  id;
        logic [WIDTH-1:0] y;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] model_f(input logic [1:0] o, input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        case (o)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return a;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [1:0] o, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b);
        op[2*k +: 2]         = o;
        a_in[WIDTH*k +: WIDTH] = a;
        b_in[WIDTH*k +: WIDTH] = b;
        req[k]               = 1'b1;
    endtask

    task automatic push_exp(input int k, input logic [1:0] o, input logic [WIDTH-1:0] a,
                            input logic [WIDTH-1:0] b);
        exp_t e;
        e.id = ID_W'(k);
        e.y  = model_f(o, a, b);
        sb_q.push_back(e);
    endtask

    task automatic wait_gnt(output int idx);
        idx = -1;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (gnt != '0) begin
                check_val("gnt_onehot", $countones(gnt), 1);
                for (int j = 0; j < NREQ; j++) if (gnt[j]) idx = j;
                break;
            end
        end
        if (idx < 0) check_val("gnt_timeout", 0, 1);
    endtask

    task automatic run_single(input int k, input logic [1:0] o, input logic [WIDTH-1:0] a,
                              input logic [WIDTH-1:0] b);
        set_req(k, o, a, b);
        push_exp(k, o, a, b);
        tick();
        check_val("single_gnt", gnt, 32'(1) << k);
        check_val("single_busy", busy, 1);
        req[k] = 1'b0;
        tick();
        check_val("single_valid", rsp_valid, 1);
        check_val("single_gnt_low", gnt, 0);
        tick();
        check_val("single_valid_drop", rsp_valid, 0);
        check_val("single_idle", busy, 0);
    endtask

    // Response monitor: valid & ready seen here is the handshake at the next edge.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                check_val("rsp_unexpected", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check_val("rsp_id", rsp_id, mon_e.id);
                check_val("rsp_y", rsp_y, mon_e.y);
`ifdef LOGIC_UNIT_ARBITER_PARITY_EN
                check_val("rsp_par", rsp_par, ^mon_e.y);
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;

        // Reset and idle
        rst_n = 1'b0;
        tick();
        tick();
        check_val("rst_gnt", gnt, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_valid", rsp_valid, 0);
        check_val("rst_id", rsp_id, 0);
        check_val("rst_y", rsp_y, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_val("idle_gnt", gnt, 0);
            check_val("idle_valid", rsp_valid, 0);
            check_val("idle_busy", busy, 0);
        end

        // Single operations, all opcodes
        run_single(2, 2'b01, 8'hA5, 8'h0F);
        run_single(2, 2'b00, 8'hA5, 8'h0F);
        run_single(2, 2'b10, 8'hA5, 8'h0F);
        run_single(2, 2'b11, 8'hA5, 8'h0F);
        run_single(1, 2'b11, 8'h01, 8'hFF);

        // Round-robin with all requesters contending
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < NREQ; k++) set_req(k, 2'(k), 8'h10 + 8'(k * 17), 8'h3C);
        for (int i = 0; i < 8; i++) begin
            push_exp(i % NREQ, 2'(i % NREQ), 8'h10 + 8'((i % NREQ) * 17), 8'h3C);
            wait_gnt(idx);
            check_val("rr_order", idx, i % NREQ);
            if (idx >= 0) begin
                req[idx] = 1'b0;
                tick();
                req[idx] = 1'b1;
            end
        end
        req = '0;
        tick();
        tick();
        check_val("rr_idle", busy, 0);

        // Backpressure: requester 0 held in RESP, requester 1 waits
        rsp_ready = 1'b0;
        set_req(0, 2'b10, 8'h33, 8'h0F);
        push_exp(0, 2'b10, 8'h33, 8'h0F);
        tick();
        check_val("bp_gnt0", gnt, 4'b0001);
        req[0] = 1'b0;
        tick();
        set_req(1, 2'b00, 8'hF0, 8'h3C);
        push_exp(1, 2'b00, 8'hF0, 8'h3C);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("bp_valid", rsp_valid, 1);
            check_val("bp_y", rsp_y, 8'h3C);
            check_val("bp_id", rsp_id, 0);
            check_val("bp_no_gnt", gnt, 0);
        end
        rsp_ready = 1'b1;
        tick();
        check_val("bp_valid_drop", rsp_valid, 0);
        check_val("bp_no_early_gnt", gnt, 0);
        tick();
        check_val("bp_gnt1", gnt, 4'b0010);
        req[1] = 1'b0;
        tick();
        tick();
        check_val("bp_idle", busy, 0);

        // Reset during EXEC of requester 3
        set_req(3, 2'b01, 8'h55, 8'hAA);
        tick();
        check_val("mid_gnt3", gnt, 4'b1000);
        req[3] = 1'b0;
        rst_n  = 1'b0;
        tick();
        check_val("mid_valid", rsp_valid, 0);
        check_val("mid_busy", busy, 0);
        check_val("mid_gnt", gnt, 0);
        rst_n = 1'b1;
        set_req(0, 2'b00, 8'hC3, 8'h81);
        set_req(3, 2'b01, 8'h55, 8'hAA);
        push_exp(0, 2'b00, 8'hC3, 8'h81);
        tick();
        check_val("mid_ptr_reset", gnt, 4'b0001);
        req = '0;
        tick();
        tick();
        tick();
        check_val("mid_idle", busy, 0);
        check_val("sb_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
